dmem_arbiter: RTL and testbench

//   Shares the single-port data memory between the CPU load/store path and a host

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// path and the host debug/loader port. The CPU has fixed priority, a host that
// has been denied MAX_WAIT cycles in a row is forced through, and the host may
// lock the bus for bursts of up to LOCK_MAX grants. Read data comes back
// registered, with a one-cycle valid strobe per requester.
module dmem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 4,
   parameter int LOCK_MAX = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   // CPU load/store port
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   // host debug/loader port
   input  logic          host_req,
   input  logic          host_we,
   input  logic          host_lock,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   // memory port
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int LW = $clog2(LOCK_MAX + 1);

   typedef enum logic {
      ARB   = 1'b0,
      HLOCK = 1'b1
   } state_t;

   state_t        state_q;
   logic [WW-1:0] wait_q;      // consecutive cycles the host was denied
   logic [LW-1:0] lock_q;      // grants already given in the current locked burst
   logic          supp_q;      // first ARB cycle after a forced lock release
   logic          cpu_rvalid_q, host_rvalid_q;
   logic [DW-1:0] cpu_rdata_q, host_rdata_q;

   logic          host_due;
   logic          lock_last;
   logic          cpu_rd, host_rd;

   assign host_due  = (wait_q == WW'(MAX_WAIT));
   // the grant being given now is the LOCK_MAX-th of the burst
   assign lock_last = ((lock_q + LW'(1)) == LW'(LOCK_MAX));

   // Grant decision: combinational from state and requests, never two at once.
   // Grants are held off while reset is asserted so nothing reaches memory.
   always_comb begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
      if (rst_n) begin
         if (state_q == HLOCK) begin
            host_gnt = host_req;
         end else if (cpu_req && (supp_q || !(host_due && host_req))) begin
            cpu_gnt = 1'b1;
         end else begin
            host_gnt = host_req;
         end
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign cpu_rd    = cpu_gnt & ~cpu_we;
   assign host_rd   = host_gnt & ~host_we;

   // Memory port mux: the granted side drives, otherwise everything is zero.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (host_gnt) begin
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   // Arbitration FSM with host starvation counter and lock burst counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB;
         wait_q  <= '0;
         lock_q  <= '0;
         supp_q  <= 1'b0;
      end else begin
         if (!host_req || host_gnt) begin
            wait_q <= '0;
         end else if (!host_due) begin
            wait_q <= wait_q + WW'(1);
         end

         case (state_q)
            ARB: begin
               supp_q <= 1'b0;
               if (host_gnt && host_lock) begin
                  state_q <= HLOCK;
                  lock_q  <= LW'(1);
               end
            end
            HLOCK: begin
               if (!host_req || !host_lock) begin
                  state_q <= ARB;
                  lock_q  <= '0;
               end else if (lock_last) begin
                  // forced release: the waiting CPU gets the next cycle
                  state_q <= ARB;
                  lock_q  <= '0;
                  supp_q  <= 1'b1;
               end else begin
                  lock_q <= lock_q + LW'(1);
               end
            end
            default: begin
               state_q <= ARB;
               lock_q  <= '0;
               supp_q  <= 1'b0;
            end
         endcase
      end
   end

   // Read return: capture memory data on a granted read, strobe valid next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rvalid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
         cpu_rdata_q   <= '0;
         host_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q  <= cpu_rd;
         host_rvalid_q <= host_rd;
         if (cpu_rd)  cpu_rdata_q  <= mem_rdata;
         if (host_rd) host_rdata_q <= mem_rdata;
      end
   end

   assign cpu_rvalid  = cpu_rvalid_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a
// policy-level reference model; read responses go through a scoreboard queue
// that a separate monitor drains whenever an rvalid strobe appears.
module tb_dmem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int MW = 4;
   localparam int LM = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_gnt, cpu_stall, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_gnt, host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .LOCK_MAX(LM)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // the data memory itself: combinational read, write on the clock edge
   logic [DW-1:0] mem [256] = '{default: 8'h00};
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   int n_chk = 0, n_fail = 0, cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // reference model: what memory should hold and the arbitration policy state
   logic [DW-1:0] ref_mem [256] = '{default: 8'h00};
   bit m_lock, m_supp;
   int m_burst, m_wait;
   bit eg_c, eg_h;
   bit [31:0] hpat, cpat;

   typedef struct { int due; logic [DW-1:0] d; } rd_t;
   rd_t cq[$], hq[$];

   task automatic model_reset();
      m_lock = 0; m_supp = 0; m_burst = 0; m_wait = 0; eg_c = 0; eg_h = 0;
   endtask

   // evaluate one cycle with current (stable) inputs, check grant-side outputs
   task automatic model_cycle();
      bit gc, gh;
      logic          ewe;
      logic [AW-1:0] ead;
      logic [DW-1:0] ewd;
      gc = 0; gh = 0;
      if (m_lock)                                             gh = host_req;
      else if (cpu_req && (m_supp || !(m_wait == MW && host_req))) gc = 1;
      else                                                    gh = host_req;
      ewe = gc ? cpu_we : (gh ? host_we : 1'b0);
      ead = gc ? cpu_addr : (gh ? host_addr : '0);
      ewd = gc ? cpu_wdata : (gh ? host_wdata : '0);
      chk("cpu_gnt", cpu_gnt, gc);
      chk("host_gnt", host_gnt, gh);
      chk("cpu_stall", cpu_stall, cpu_req & !gc);
      chk("mem_we", mem_we, ewe);
      chk("mem_addr", mem_addr, ead);
      chk("mem_wdata", mem_wdata, ewd);
      if (gc && !cpu_we)  cq.push_back('{cyc + 1, ref_mem[cpu_addr]});
      if (gh && !host_we) hq.push_back('{cyc + 1, ref_mem[host_addr]});
      if (gc && cpu_we)  ref_mem[cpu_addr]  = cpu_wdata;
      if (gh && host_we) ref_mem[host_addr] = host_wdata;
      if (!host_req || gh) m_wait = 0;
      else if (m_wait < MW) m_wait++;
      if (m_lock) begin
         if (!host_req || !host_lock) m_lock = 0;
         else begin
            m_burst++;
            if (m_burst == LM) begin m_lock = 0; m_supp = 1; end
         end
      end else begin
         m_supp = 0;
         if (gh && host_lock) begin m_lock = 1; m_burst = 1; end
      end
      eg_c = gc; eg_h = gh;
   endtask

   task automatic step();
      @(negedge clk);
      if (rst_n) model_cycle();
      hpat = {hpat[30:0], host_gnt};
      cpat = {cpat[30:0], cpu_gnt};
      @(posedge clk); #1;
   endtask

   task automatic cpu_set(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
      cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
   endtask
   task automatic host_set(input logic r, input logic w, input logic l, input logic [7:0] a,
                           input logic [7:0] d);
      host_req = r; host_we = w; host_lock = l; host_addr = a; host_wdata = d;
   endtask

   // monitor: drains the read scoreboard and checks rdata holding between reads
   logic [DW-1:0] last_c = '0, last_h = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_cpu_rvalid", cpu_rvalid, 0);
         chk("rst_host_rvalid", host_rvalid, 0);
         chk("rst_cpu_rdata", cpu_rdata, 0);
         chk("rst_host_rdata", host_rdata, 0);
         last_c = '0; last_h = '0;
      end else begin
         if (cpu_rvalid) begin
            if (cq.size() == 0) chk("cpu_rvalid_spurious", cpu_rvalid, 0);
            else begin
               rd_t e;
               e = cq.pop_front();
               chk("cpu_rvalid_cycle", cyc, e.due);
               chk("cpu_rdata", cpu_rdata, e.d);
               last_c = e.d;
            end
         end else begin
            if (cq.size() > 0 && cq[0].due <= cyc) begin
               chk("cpu_rvalid_missing", cpu_rvalid, 1);
               void'(cq.pop_front());
            end
            chk("cpu_rdata_hold", cpu_rdata, last_c);
         end
         if (host_rvalid) begin
            if (hq.size() == 0) chk("host_rvalid_spurious", host_rvalid, 0);
            else begin
               rd_t e;
               e = hq.pop_front();
               chk("host_rvalid_cycle", cyc, e.due);
               chk("host_rdata", host_rdata, e.d);
               last_h = e.d;
            end
         end else begin
            if (hq.size() > 0 && hq[0].due <= cyc) begin
               chk("host_rvalid_missing", host_rvalid, 1);
               void'(hq.pop_front());
            end
            chk("host_rdata_hold", host_rdata, last_h);
         end
      end
   end

   initial begin
      int hcnt, n;
      model_reset();
      // reset: no grant even with a request pending
      cpu_set(1, 0, 8'h10, 8'h00);
      @(negedge clk);
      chk("rst_no_gnt", {cpu_gnt, host_gnt, mem_we}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(posedge clk); #1;
      cpu_set(0, 0, 8'h00, 8'h00);
      rst_n = 1'b1;

      // host preloads 0xA5 at 0x10, then a lone CPU load
      host_set(1, 1, 0, 8'h10, 8'hA5); step();
      host_set(0, 0, 0, 8'h00, 8'h00);
      cpu_set(1, 0, 8'h10, 8'h00); step();
      cpu_set(0, 0, 8'h00, 8'h00); step(); step();

      // contention: host forced through every MAX_WAIT+1 cycles
      cpu_set(1, 0, 8'h10, 8'h00);
      host_set(1, 0, 0, 8'h11, 8'h00);
      repeat (10) step();
      chk("contention_pattern", hpat[9:0], 10'b0000100001);
      cpu_set(0, 0, 8'h00, 8'h00);
      host_set(0, 0, 0, 8'h00, 8'h00);
      step();

      // host write then CPU load of the same location
      host_set(1, 1, 0, 8'h20, 8'h3C); step();
      host_set(0, 0, 0, 8'h00, 8'h00);
      cpu_set(1, 0, 8'h20, 8'h00); step();
      cpu_set(0, 0, 8'h00, 8'h00); step(); step();

      // locked host burst of 20 against a continuously requesting CPU
      cpu_set(1, 1, 8'h30, 8'h77);
      host_set(1, 0, 1, 8'h20, 8'h00);
      hcnt = 0; n = 0;
      repeat (22) begin step(); if (hpat[0]) hcnt++; n++; end
      chk("lock_burst_pattern", hpat[21:0], {4'b0000, 16'hFFFF, 2'b00});
      while (hcnt < 20 && n < 200) begin step(); if (hpat[0]) hcnt++; n++; end
      if (hcnt < 20) chk("lock_burst_timeout", hcnt, 20);
      host_set(0, 0, 0, 8'h00, 8'h00);
      cpu_set(0, 0, 8'h00, 8'h00);
      step(); step();

      // lock held but host_req drops after 3 grants: CPU gets in after one cycle
      host_set(1, 0, 1, 8'h30, 8'h00);
      repeat (3) step();
      host_set(0, 0, 0, 8'h00, 8'h00);
      cpu_set(1, 0, 8'h20, 8'h00);
      step(); step();
      chk("unlock_host_pattern", hpat[4:0], 5'b11100);
      chk("unlock_cpu_pattern", cpat[1:0], 2'b01);

      // async reset right after a granted load: rvalid pulse cancelled
      rst_n = 1'b0;
      cq.delete(); hq.delete();
      model_reset();
      @(negedge clk);
      chk("rst_mid_no_gnt", {cpu_gnt, host_gnt, mem_we}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cpu_set(0, 0, 8'h00, 8'h00);
      step();

      // randomized traffic; a pending request holds its fields until granted
      repeat (3000) begin
         if (!cpu_req || eg_c)
            cpu_set(($urandom % 10) < 6, $urandom % 2, 8'($urandom_range(0, 31)), 8'($urandom));
         if (!host_req || eg_h)
            host_set(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) != 0,
                     8'($urandom_range(0, 31)), 8'($urandom));
         step();
      end
      cpu_set(0, 0, 8'h00, 8'h00);
      host_set(0, 0, 0, 8'h00, 8'h00);
      repeat (3) step();
      chk("cpu_queue_drained", cq.size(), 0);
      chk("host_queue_drained", hq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
